// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result streams for pipelined_adder.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  // Operand producer and result consumer
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum
  );

endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES chunks, one chunk
// resolved per stage, with valid/ready flow control and collapsing bubbles.
// Optional feature macro: PIPELINED_ADDER_CNT_EN adds a 16-bit output transfer
// counter on port xfer_cnt.
module pipelined_adder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned HAS_CIN = 0,
  parameter int unsigned STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef PIPELINED_ADDER_CNT_EN
  output logic [15:0] xfer_cnt,
`endif
  pipelined_adder_if.slave bus
);

  localparam int unsigned CHUNK = (WIDTH + STAGES - 1) / STAGES;

  // Stage s register set; stage STAGES-1 drives the output port
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];

  // Values presented to the input of stage s
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];

  // Next contents of each stage after adding its chunk
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             cy_d  [STAGES];
  logic             carry_c;

  // rdy_c[s] = stage s may load; rdy_c[STAGES] is the consumer
  logic             rdy_c [STAGES+1];

  // Last stage keeps operand copies nobody reads
  logic             unused_ops;
  assign unused_ops = ^{opa_q[STAGES-1], opb_q[STAGES-1]};

  // Stage inputs: ports for stage 0, previous stage registers otherwise
  always_comb begin
    src_v[0] = bus.in_valid;
    src_a[0] = bus.a;
    src_b[0] = bus.b;
    src_s[0] = '0;
    src_c[0] = (HAS_CIN != 0) ? bus.cin : 1'b0;
    for (int unsigned s = 1; s < STAGES; s++) begin
      src_v[s] = vld_q[s-1];
      src_a[s] = opa_q[s-1];
      src_b[s] = opb_q[s-1];
      src_s[s] = sum_q[s-1];
      src_c[s] = cy_q[s-1];
    end
  end

  // Ripple-add chunk s inside stage s; an empty trailing chunk passes the carry
  always_comb begin
    carry_c = 1'b0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      sum_d[s] = src_s[s];
      carry_c  = src_c[s];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if ((i >= s * CHUNK) && (i < (s + 1) * CHUNK)) begin
          sum_d[s][i] = src_a[s][i] ^ src_b[s][i] ^ carry_c;
          carry_c     = (src_a[s][i] & src_b[s][i]) |
                        (carry_c & (src_a[s][i] ^ src_b[s][i]));
        end
      end
      cy_d[s] = carry_c;
    end
  end

  // Backpressure: a stage loads when empty or when its successor moves on
  always_comb begin
    rdy_c[STAGES] = bus.out_ready;
    for (int unsigned s = 0; s < STAGES; s++) begin
      rdy_c[STAGES-1-s] = !vld_q[STAGES-1-s] || rdy_c[STAGES-s];
    end
  end

  // Pipeline registers; payload only captured alongside a valid item
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        opa_q[s] <= '0;
        opb_q[s] <= '0;
        sum_q[s] <= '0;
        cy_q[s]  <= 1'b0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (rdy_c[s]) begin
          vld_q[s] <= src_v[s];
          if (src_v[s]) begin
            opa_q[s] <= src_a[s];
            opb_q[s] <= src_b[s];
            sum_q[s] <= sum_d[s];
            cy_q[s]  <= cy_d[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy_c[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = {cy_q[STAGES-1], sum_q[STAGES-1]};

`ifdef PIPELINED_ADDER_CNT_EN
  // Free-running count of output transfers, wraps at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 16'd0;
    end else if (bus.out_valid && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 34-bit/2-stage instance without carry-in
// and an 8-bit/4-stage instance with carry-in share one clock and reset.
module tb_pipelined_adder;

  localparam int unsigned W0 = 34;
  localparam int unsigned S0 = 2;
  localparam int unsigned W1 = 8;
  localparam int unsigned S1 = 4;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned N_RAND1 = 10000;
  localparam int unsigned N_RAND0 = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  bit lat_chk = 1'b0;

  logic [W0:0] sb0 [$];
  int unsigned ts0 [$];
  logic [W1:0] sb1 [$];
  int unsigned ts1 [$];
  int unsigned n_out0 = 0;
  int unsigned n_out1 = 0;
  bit          hold0 = 1'b0;
  bit          hold1 = 1'b0;
  logic [W0:0] held0;
  logic [W1:0] held1;
  bit          done0;
  bit          done1;
  int unsigned base;

  pipelined_adder_if #(.WIDTH(W0)) bus0 ();
  pipelined_adder_if #(.WIDTH(W1)) bus1 ();

`ifdef PIPELINED_ADDER_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  pipelined_adder #(.WIDTH(W0), .HAS_CIN(0), .STAGES(S0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef PIPELINED_ADDER_CNT_EN
    .xfer_cnt (cnt0),
`endif
    .bus      (bus0)
  );

  pipelined_adder #(.WIDTH(W1), .HAS_CIN(1), .STAGES(S1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef PIPELINED_ADDER_CNT_EN
    .xfer_cnt (cnt1),
`endif
    .bus      (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and stall monitor, 34-bit instance
  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        check("stall_valid0", 64'(bus0.out_valid), 64'd1);
        check("stall_sum0", 64'(bus0.sum), 64'(held0));
      end
      hold0 = bus0.out_valid && !bus0.out_ready;
      held0 = bus0.sum;
      if (bus0.out_valid && bus0.out_ready) begin
        n_out0++;
        check("sb0_nonempty", 64'(sb0.size() != 0), 64'd1);
        if (sb0.size() != 0) begin
          logic [W0:0] e;
          int unsigned t;
          e = sb0.pop_front();
          t = ts0.pop_front();
          check("sum0", 64'(bus0.sum), 64'(e));
          if (lat_chk) check("latency0", 64'(cyc - t), 64'(S0));
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        sb0.push_back((W0+1)'(bus0.a) + (W0+1)'(bus0.b));
        ts0.push_back(cyc);
      end
    end
  end

  // Scoreboard and stall monitor, 8-bit instance with carry-in
  always @(negedge clk) begin
    if (!rst_n) begin
      hold1 = 1'b0;
    end else begin
      if (hold1) begin
        check("stall_valid1", 64'(bus1.out_valid), 64'd1);
        check("stall_sum1", 64'(bus1.sum), 64'(held1));
      end
      hold1 = bus1.out_valid && !bus1.out_ready;
      held1 = bus1.sum;
      if (bus1.out_valid && bus1.out_ready) begin
        n_out1++;
        check("sb1_nonempty", 64'(sb1.size() != 0), 64'd1);
        if (sb1.size() != 0) begin
          logic [W1:0] e;
          int unsigned t;
          e = sb1.pop_front();
          t = ts1.pop_front();
          check("sum1", 64'(bus1.sum), 64'(e));
          if (lat_chk) check("latency1", 64'(cyc - t), 64'(S1));
        end
      end
      if (bus1.in_valid && bus1.in_ready) begin
        sb1.push_back((W1+1)'(bus1.a) + (W1+1)'(bus1.b) + (W1+1)'(bus1.cin));
        ts1.push_back(cyc);
      end
    end
  end

  task automatic send0(input logic [W0-1:0] av, input logic [W0-1:0] bv);
    int unsigned g = 0;
    bus0.in_valid = 1'b1;
    bus0.a = av;
    bus0.b = bv;
    bus0.cin = 1'b0;
    @(negedge clk);
    while (!bus0.in_ready && g < TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    if (g >= TIMEOUT) check("send0_timeout", 64'(bus0.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [W1-1:0] av, input logic [W1-1:0] bv, input logic cv);
    int unsigned g = 0;
    bus1.in_valid = 1'b1;
    bus1.a = av;
    bus1.b = bv;
    bus1.cin = cv;
    @(negedge clk);
    while (!bus1.in_ready && g < TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    if (g >= TIMEOUT) check("send1_timeout", 64'(bus1.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain0();
    int unsigned g = 0;
    while (sb0.size() != 0 && g < TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    check("drain0", 64'(sb0.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain1();
    int unsigned g = 0;
    while (sb1.size() != 0 && g < TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    check("drain1", 64'(sb1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expired, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid0", 64'(bus0.out_valid), 64'd0);
    check("rst_sum0", 64'(bus0.sum), 64'd0);
    check("rst_in_ready0", 64'(bus0.in_ready), 64'd1);
    check("rst_out_valid1", 64'(bus1.out_valid), 64'd0);
    check("rst_sum1", 64'(bus1.sum), 64'd0);
    check("rst_in_ready1", 64'(bus1.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single items with latency checking
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    lat_chk = 1'b1;
    send0(34'h3_FFFF_FFFF, 34'h1); drain0();
    send0(34'h0_0001_FFFF, 34'h1); drain0();
    send0(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF); drain0();
    send0(34'h0_0000_0000, 34'h0_0000_0000); drain0();
    send1(8'hFF, 8'h00, 1'b1); drain1();
    send1(8'hFF, 8'hFF, 1'b1); drain1();
    send1(8'h55, 8'hAA, 1'b0); drain1();
    send1(8'h03, 8'h01, 1'b0); drain1();
    lat_chk = 1'b0;

    // Stream 0..15 through the 2-stage instance with a 5-cycle output stall
    base = n_out0;
    fork
      begin
        for (int i = 0; i < 16; i++) send0(W0'(i), W0'(i));
      end
      begin
        int unsigned g3 = 0;
        while (!bus0.out_valid && g3 < TIMEOUT) begin
          @(negedge clk);
          g3++;
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("full_in_ready0", 64'(bus0.in_ready), 64'd0);
        check("full_out_valid0", 64'(bus0.out_valid), 64'd1);
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
      end
    join
    drain0();
    check("stream_count0", 64'(n_out0 - base), 64'd16);

    // Random valid/ready traffic on both instances at once
    base = n_out1;
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin
        for (int i = 0; i < int'(N_RAND1); i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send1(W1'($urandom), W1'($urandom), 1'($urandom));
        end
        done1 = 1'b1;
      end
      begin
        while (!done1) begin
          bus1.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus1.out_ready = 1'b1;
      end
      begin
        for (int j = 0; j < int'(N_RAND0); j++) begin
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
          end
          send0(W0'({$urandom, $urandom}), W0'({$urandom, $urandom}));
        end
        done0 = 1'b1;
      end
      begin
        while (!done0) begin
          bus0.out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        bus0.out_ready = 1'b1;
      end
    join
    drain1();
    drain0();
    check("rand_count1", 64'(n_out1 - base), 64'(N_RAND1));

    // Reset with three items in flight in the 4-stage instance
    bus1.out_ready = 1'b0;
    send1(8'h01, 8'h02, 1'b0);
    send1(8'h03, 8'h04, 1'b0);
    send1(8'h05, 8'h06, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_valid1", 64'(bus1.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid1", 64'(bus1.out_valid), 64'd0);
    check("async_rst_sum1", 64'(bus1.sum), 64'd0);
    sb1.delete();
    ts1.delete();
    sb0.delete();
    ts0.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready1", 64'(bus1.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b1;
    base = n_out1;
    repeat (10) @(negedge clk);
    check("no_stale_valid1", 64'(bus1.out_valid), 64'd0);
    check("no_stale_count1", 64'(n_out1 - base), 64'd0);
    @(posedge clk);
    #1;
    send1(8'h10, 8'h20, 1'b1);
    drain1();

`ifdef PIPELINED_ADDER_CNT_EN
    // Output transfer counter wraps after 65536 transfers
    rst_n = 1'b0;
    #2;
    check("cnt0_rst", 64'(cnt0), 64'd0);
    sb0.delete();
    ts0.delete();
    sb1.delete();
    ts1.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 65537; k++) send0(W0'(k), W0'(1));
    drain0();
    check("cnt0_wrap", 64'(cnt0), 64'd1);
    check("cnt1_idle", 64'(cnt1), 64'd0);
    rst_n = 1'b0;
    #2;
    check("cnt0_rst_again", 64'(cnt0), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
